uart_rx_frame_ctrl: RTL and testbench

//  Frame controller for the UART receive path. Sits around the 3-sample majority-vote sampler.
//  - Detects the start bit.
//  - Drives the sampler's enable and edge count; consumes the voted SAMPLED_BIT once per bit.
//  - Deserialises data LSB-first, checks parity and stop bit.
//  - Presents the parallel byte with a one-cycle valid strobe.

---
 rtl/uart_rx_frame_ctrl.sv | 158 +++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start detect, sampler drive, LSB-first deserialise, parity/stop check.
// Optional macro UART_RX_STICKY_ERR_EN makes PAR_ERR/STP_ERR hold until the next frame's data phase.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic [PRESC_WIDTH-1:0] PRESCALE,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic                   SAMPLED_BIT,
  output logic                   DAT_SAMP_EN,
  output logic [PRESC_WIDTH:0]   EDGE_CNT,
  output logic [DATA_WIDTH-1:0]  P_DATA,
  output logic                   DATA_VALID,
  output logic                   PAR_ERR,
  output logic                   STP_ERR
);

  localparam int CNT_W = PRESC_WIDTH + 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0]       LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [PRESC_WIDTH-1:0] MIN_PS   = PRESC_WIDTH'(8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state;
  logic [PRESC_WIDTH-1:0] ps_q;
  logic                   par_en_q;
  logic                   par_typ_q;
  logic                   par_mis_q;
  logic [DATA_WIDTH-1:0]  shift_q;
  logic [BIT_W-1:0]       bit_cnt;

  logic [PRESC_WIDTH-1:0] ps_eff;
  logic [CNT_W-1:0]       last_edge;
  logic                   bit_end;
  logic                   exp_par;
  logic                   frame_ok;

  // The sampler votes on three edges after mid-bit, so short prescales are clamped up.
  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    ps_eff    = (PRESCALE < MIN_PS) ? MIN_PS : PRESCALE;
    last_edge = {1'b0, ps_q} - CNT_W'(1);
    bit_end   = (EDGE_CNT == last_edge);
    exp_par   = (^shift_q) ^ par_typ_q;
    frame_ok  = SAMPLED_BIT && !par_mis_q;
  end

  // NOTE: reset is synchronous and, like all state here, updated with non-blocking
  // assignments so every register sees pre-edge values of its neighbours.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      ps_q        <= '0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      par_mis_q   <= 1'b0;
      shift_q     <= '0;
      bit_cnt     <= '0;
      DAT_SAMP_EN <= 1'b0;
      EDGE_CNT    <= '0;
      P_DATA      <= '0;
      DATA_VALID  <= 1'b0;
      PAR_ERR     <= 1'b0;
      STP_ERR     <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
`ifdef UART_RX_STICKY_ERR_EN
      // Flags hold here; they are cleared when the next frame enters its data phase.
`else
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
`endif

      if (DAT_SAMP_EN) begin
        EDGE_CNT <= bit_end ? '0 : EDGE_CNT + CNT_W'(1);
      end

      case (state)
        S_IDLE: begin
          EDGE_CNT <= '0;
          if (!RX_IN) begin
            state       <= S_START;
            DAT_SAMP_EN <= 1'b1;
            ps_q        <= ps_eff;
            par_en_q    <= PAR_EN;
            par_typ_q   <= PAR_TYP;
          end
        end

        S_START: begin
          if (bit_end) begin
            if (SAMPLED_BIT) begin
              // Line was high again at mid-bit: a glitch, not a frame.
              state       <= S_IDLE;
              DAT_SAMP_EN <= 1'b0;
            end else begin
              state     <= S_DATA;
              bit_cnt   <= '0;
              par_mis_q <= 1'b0;
`ifdef UART_RX_STICKY_ERR_EN
              PAR_ERR   <= 1'b0;
              STP_ERR   <= 1'b0;
`endif
            end
          end
        end

        S_DATA: begin
          if (bit_end) begin
            shift_q[bit_cnt] <= SAMPLED_BIT;
            if (bit_cnt == LAST_BIT) begin
              state <= par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            par_mis_q <= (SAMPLED_BIT != exp_par);
            state     <= S_STOP;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            state       <= S_IDLE;
            DAT_SAMP_EN <= 1'b0;
            PAR_ERR     <= par_mis_q;
            STP_ERR     <= ~SAMPLED_BIT;
            if (frame_ok) begin
              P_DATA     <= shift_q;
              DATA_VALID <= 1'b1;
            end
          end
        end

        default: begin
          state       <= S_IDLE;
          DAT_SAMP_EN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl; the sampler is modelled as the line value at bit end.
// Flag-hold expectations follow UART_RX_STICKY_ERR_EN when it is defined for the build.
module tb_uart_rx_frame_ctrl;

`ifdef UART_RX_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       SAMPLED_BIT;
  logic       DAT_SAMP_EN;
  logic [6:0] EDGE_CNT;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  assign SAMPLED_BIT = RX_IN;

  uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PRESCALE   (PRESCALE),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .SAMPLED_BIT(SAMPLED_BIT),
    .DAT_SAMP_EN(DAT_SAMP_EN),
    .EDGE_CNT   (EDGE_CNT),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
    logic       par;
    logic       stp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  logic mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a frame ends when DATA_VALID pulses or an error flag rises.
  logic prev_p = 1'b0, prev_s = 1'b0, prev_dv = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (mon_en && (DATA_VALID === 1'b1 || (PAR_ERR === 1'b1 && !prev_p) ||
                   (STP_ERR === 1'b1 && !prev_s))) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_frame: dv=%b p_data=0x%0h par=%b stp=%b, none expected",
                 DATA_VALID, P_DATA, PAR_ERR, STP_ERR);
      end else begin
        e = sb_q.pop_front();
        check("data_valid", 32'(DATA_VALID), 32'(e.valid));
        check("p_data",     32'(P_DATA),     32'(e.data));
        check("par_err",    32'(PAR_ERR),    32'(e.par));
        check("stp_err",    32'(STP_ERR),    32'(e.stp));
        if (DATA_VALID === 1'b1) check("dv_one_cycle", 32'(prev_dv), 32'd0);
      end
    end
    prev_p  = (PAR_ERR === 1'b1);
    prev_s  = (STP_ERR === 1'b1);
    prev_dv = (DATA_VALID === 1'b1);
  end

  task automatic send_bit(input logic v, input int ps);
    RX_IN = v;
    repeat (ps) @(negedge CLK);
  endtask

  // Frame settings are scrambled right after start detection to show they are latched.
  task automatic send_frame(input logic [7:0] d, input int ps, input logic [5:0] presc,
                            input logic pe, input logic pt, input logic pbit, input logic stop);
    PRESCALE = presc;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    RX_IN    = 1'b0;
    @(negedge CLK);
    PRESCALE = ~presc;
    PAR_EN   = ~pe;
    PAR_TYP  = ~pt;
    send_bit(1'b0, ps);
    for (int i = 0; i < 8; i++) send_bit(d[i], ps);
    if (pe) send_bit(pbit, ps);
    send_bit(stop, ps);
    PRESCALE = presc;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    RX_IN    = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dat_samp_en"}, 32'(DAT_SAMP_EN), 32'd0);
    check({tag, "_edge_cnt"},    32'(EDGE_CNT),    32'd0);
    check({tag, "_p_data"},      32'(P_DATA),      32'd0);
    check({tag, "_data_valid"},  32'(DATA_VALID),  32'd0);
    check({tag, "_par_err"},     32'(PAR_ERR),     32'd0);
    check({tag, "_stp_err"},     32'(STP_ERR),     32'd0);
  endtask

  initial begin
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check_idle_outputs("reset");
    RST = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge CLK);

    // Clean 0xA5, PS=8, no parity.
    sb_q.push_back('{valid: 1'b1, data: 8'hA5, par: 1'b0, stp: 1'b0});
    send_frame(8'hA5, 8, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge CLK);

    // PRESCALE below the floor behaves as 8.
    sb_q.push_back('{valid: 1'b1, data: 8'h3C, par: 1'b0, stp: 1'b0});
    send_frame(8'h3C, 8, 6'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge CLK);

    // 0x03, even parity, parity bit 1 -> parity error, P_DATA holds 0x3C.
    sb_q.push_back('{valid: 1'b0, data: 8'h3C, par: 1'b1, stp: 1'b0});
    send_frame(8'h03, 16, 6'd16, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge CLK);
    check("par_err_hold", 32'(PAR_ERR), 32'(STICKY));

    // Glitch: line low for 3 cycles, high at bit end.
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    @(negedge CLK);
    check("glitch_en_rise", 32'(DAT_SAMP_EN), 32'd1);
    check("glitch_cnt0",    32'(EDGE_CNT),    32'd0);
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (5) @(negedge CLK);
    check("glitch_en_hold", 32'(DAT_SAMP_EN), 32'd1);
    check("glitch_cnt7",    32'(EDGE_CNT),    32'd7);
    @(negedge CLK);
    check("glitch_en_fall", 32'(DAT_SAMP_EN), 32'd0);
    check("glitch_cnt_clr", 32'(EDGE_CNT),    32'd0);
    check("glitch_par_err", 32'(PAR_ERR),     32'(STICKY));
    check("glitch_stp_err", 32'(STP_ERR),     32'd0);
    repeat (3) @(negedge CLK);

    // 0x55 with stop bit low, then clean 0x0F.
    sb_q.push_back('{valid: 1'b0, data: 8'h3C, par: 1'b0, stp: 1'b1});
    send_frame(8'h55, 8, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    check("stp_err_hold", 32'(STP_ERR), 32'(STICKY));
    sb_q.push_back('{valid: 1'b1, data: 8'h0F, par: 1'b0, stp: 1'b0});
    send_frame(8'h0F, 8, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge CLK);
    check("clean_clears_stp", 32'(STP_ERR), 32'd0);

    // Back-to-back 0x81 and 0x7E, PS=32, odd parity (both bytes have even weight -> bit 1).
    sb_q.push_back('{valid: 1'b1, data: 8'h81, par: 1'b0, stp: 1'b0});
    sb_q.push_back('{valid: 1'b1, data: 8'h7E, par: 1'b0, stp: 1'b0});
    send_frame(8'h81, 32, 6'd32, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(8'h7E, 32, 6'd32, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge CLK);

    // Reset during data bit 4 discards the frame; then 0xC3 arrives cleanly.
    PRESCALE = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    @(negedge CLK);
    send_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 8);
    send_bit(1'b1, 3);
    RST = 1'b1;
    @(negedge CLK);
    check_idle_outputs("midframe_rst");
    RST = 1'b0;
    repeat (12) @(negedge CLK);
    check("after_rst_quiet", 32'(DAT_SAMP_EN), 32'd0);
    sb_q.push_back('{valid: 1'b1, data: 8'hC3, par: 1'b0, stp: 1'b0});
    send_frame(8'hC3, 8, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge CLK);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
